uart_tx_scheduler: RTL

- Shares the UART transmit FIFO between NUM_REQ frame requesters, e.g. the debug-dump engine and a command-echo path.
- Grants one requester at a time, round-robin, at frame granularity.
- Walks the granted requester's bytes by index and pushes them into the FIFO, honouring fifo_full backpressure.
- Sits between the requesters and the UART TX FIFO write port.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 32 +++
 rtl/uart_tx_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART TX frame scheduler
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  localparam int REQ_DEBUG = 0;
  localparam int REQ_ECHO  = 1;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] sel,
  output logic [IDX_W-1:0]   selIdx
);

  int  cand;
  logic found;

  // Search last_grant+1 .. last_grant+NUM_REQ so the previous owner is tried last.
  always_comb begin
    sel    = '0;
    selIdx = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        sel[cand] = 1'b1;
        selIdx    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - frame-granular round-robin writer into the UART TX FIFO
// Optional SOF/ID header per frame with UART_TX_FRAME_HEADER_EN.
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LEN_W-1:0]         byte_idx,
  output logic [NUM_REQ-1:0]       req_done,
  input  logic                     fifo_full,
  output logic                     fifo_wr,
  output logic [7:0]               fifo_data,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               stateQ, stateD;
  logic [NUM_REQ-1:0]   grantQ, grantD;
  logic [IDX_W-1:0]     selQ, selD;
  logic [IDX_W-1:0]     lastGrantQ, lastGrantD;
  logic [LEN_W-1:0]     lenQ, lenD;
  logic [LEN_W-1:0]     byteIdxQ, byteIdxD;
  logic [NUM_REQ-1:0]   arbSel;
  logic [IDX_W-1:0]     arbIdx;
`ifdef UART_TX_FRAME_HEADER_EN
  logic                 hdrQ, hdrD;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uArb (
    .req_valid  (req_valid),
    .last_grant (lastGrantQ),
    .sel        (arbSel),
    .selIdx     (arbIdx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ     <= IDLE;
      grantQ     <= '0;
      selQ       <= '0;
      lastGrantQ <= IDX_W'(NUM_REQ - 1);
      lenQ       <= '0;
      byteIdxQ   <= '0;
`ifdef UART_TX_FRAME_HEADER_EN
      hdrQ       <= 1'b0;
`endif
    end else begin
      stateQ     <= stateD;
      grantQ     <= grantD;
      selQ       <= selD;
      lastGrantQ <= lastGrantD;
      lenQ       <= lenD;
      byteIdxQ   <= byteIdxD;
`ifdef UART_TX_FRAME_HEADER_EN
      hdrQ       <= hdrD;
`endif
    end
  end

  always_comb begin
    stateD     = stateQ;
    grantD     = grantQ;
    selD       = selQ;
    lastGrantD = lastGrantQ;
    lenD       = lenQ;
    byteIdxD   = byteIdxQ;
    fifo_wr    = 1'b0;
    fifo_data  = 8'h00;
`ifdef UART_TX_FRAME_HEADER_EN
    hdrD       = hdrQ;
`endif
    case (stateQ)
      IDLE: begin
        if (|req_valid) begin
          grantD   = arbSel;
          selD     = arbIdx;
          lenD     = req_len[int'(arbIdx)*LEN_W +: LEN_W];
          byteIdxD = '0;
`ifdef UART_TX_FRAME_HEADER_EN
          hdrD     = 1'b0;
          stateD   = HDR;
`else
          stateD   = (lenD == '0) ? DONE : XFER;
`endif
        end
      end
`ifdef UART_TX_FRAME_HEADER_EN
      HDR: begin
        fifo_wr   = !fifo_full;
        fifo_data = hdrQ ? {5'b0, 3'(selQ)} : SOF_BYTE;
        if (fifo_wr) begin
          if (hdrQ) stateD = (lenQ == '0) ? DONE : XFER;
          else      hdrD   = 1'b1;
        end
      end
`endif
      XFER: begin
        fifo_wr   = !fifo_full;
        fifo_data = req_data[int'(selQ)*8 +: 8];
        // The last byte leaves byte_idx at len_q-1 rather than wrapping past it.
        if (fifo_wr) begin
          if (byteIdxQ == lenQ - LEN_W'(1)) stateD   = DONE;
          else                              byteIdxD = byteIdxQ + LEN_W'(1);
        end
      end
      DONE: begin
        grantD     = '0;
        lastGrantD = selQ;
        stateD     = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  assign grant    = grantQ;
  assign byte_idx = byteIdxQ;
  assign busy     = (stateQ != IDLE);
  assign req_done = (stateQ == DONE) ? grantQ : '0;

endmodule
